// File: rtl/cv32e40x_pkg.sv
// Shared types for the instruction aligner: alignment FSM states.
package cv32e40x_pkg;

  typedef enum logic [1:0] {
    ALIGN_WORD = 2'd0,
    ALIGN_HALF = 2'd1,
    ALIGN_SKIP = 2'd2
  } align_state_e;

  localparam logic [1:0] OPC_32B = 2'b11;

  function automatic logic is_32b(input logic [15:0] hw);
    return hw[1:0] == OPC_32B;
  endfunction

endpackage

// File: rtl/cv32e40x_instr_aligner.sv
// Turns word-aligned fetch data into whole RV32IC instructions with halfword PCs.
//
//  state      | meaning
//  -----------+-----------------------------------------------------------
//  ALIGN_WORD | pc word aligned, no residual; issue from fetch word
//  ALIGN_HALF | res_q holds upper half of last word; pc points at it
//  ALIGN_SKIP | pc[1]=1 after redirect; drop low half of next word
module cv32e40x_instr_aligner
  import cv32e40x_pkg::*;
#(
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_valid_i,
  input  logic [31:0] fetch_rdata_i,
  input  logic        fetch_err_i,
  output logic        fetch_ready_o,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_rdata_o,
  output logic [31:0] instr_addr_o,
  output logic        instr_err_o
);

  localparam logic [31:0] BOOT_PC = BOOT_ADDR & ~32'd1;
  localparam align_state_e BOOT_STATE = BOOT_ADDR[1] ? ALIGN_SKIP : ALIGN_WORD;

  align_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [15:0]  res_q, res_d;
  logic         res_err_q, res_err_d;
  logic         issue_valid, fetch_take;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= BOOT_STATE;
      pc_q      <= BOOT_PC;
      res_q     <= 16'h0;
      res_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      res_q     <= res_d;
      res_err_q <= res_err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    res_d         = res_q;
    res_err_d     = res_err_q;
    issue_valid   = 1'b0;
    fetch_take    = 1'b0;
    instr_rdata_o = 32'h0;
    instr_err_o   = 1'b0;

    unique case (state_q)
      ALIGN_WORD: begin
        if (fetch_valid_i) begin
          issue_valid = 1'b1;
          instr_err_o = fetch_err_i;
          if (is_32b(fetch_rdata_i[15:0])) begin
            instr_rdata_o = fetch_rdata_i;
            if (instr_ready_i) begin
              fetch_take = 1'b1;
              pc_d       = pc_q + 32'd4;
            end
          end else begin
            instr_rdata_o = {16'h0, fetch_rdata_i[15:0]};
            if (instr_ready_i) begin
              fetch_take = 1'b1;
              res_d      = fetch_rdata_i[31:16];
              res_err_d  = fetch_err_i;
              pc_d       = pc_q + 32'd2;
              state_d    = ALIGN_HALF;
            end
          end
        end
      end
      ALIGN_HALF: begin
        if (!is_32b(res_q)) begin
          issue_valid   = 1'b1;
          instr_rdata_o = {16'h0, res_q};
          instr_err_o   = res_err_q;
          if (instr_ready_i) begin
            pc_d    = pc_q + 32'd2;
            state_d = ALIGN_WORD;
          end
        end else if (fetch_valid_i) begin
          // Straddling instruction: low half from residual, high half from new word.
          issue_valid   = 1'b1;
          instr_rdata_o = {fetch_rdata_i[15:0], res_q};
          instr_err_o   = res_err_q | fetch_err_i;
          if (instr_ready_i) begin
            fetch_take = 1'b1;
            res_d      = fetch_rdata_i[31:16];
            res_err_d  = fetch_err_i;
            pc_d       = pc_q + 32'd4;
          end
        end
      end
      ALIGN_SKIP: begin
        if (fetch_valid_i) begin
          fetch_take = 1'b1;
          res_d      = fetch_rdata_i[31:16];
          res_err_d  = fetch_err_i;
          state_d    = ALIGN_HALF;
        end
      end
      default: state_d = ALIGN_WORD;
    endcase

    // Redirect overrides any in-flight issue or fetch consumption.
    if (branch_i) begin
      issue_valid = 1'b0;
      fetch_take  = 1'b0;
      pc_d        = branch_addr_i & ~32'd1;
      res_d       = 16'h0;
      res_err_d   = 1'b0;
      state_d     = branch_addr_i[1] ? ALIGN_SKIP : ALIGN_WORD;
    end
  end

  assign instr_valid_o = issue_valid & ~rst;
  assign fetch_ready_o = fetch_take & ~rst;
  assign instr_addr_o  = pc_q;

endmodule

// File: tb/tb_cv32e40x_instr_aligner.sv
// Directed self-checking bench for the instruction aligner (BOOT_ADDR = 0x80).
module tb_cv32e40x_instr_aligner;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_valid_i;
  logic [31:0] fetch_rdata_i;
  logic        fetch_err_i;
  logic        fetch_ready_o;
  logic        branch_i;
  logic [31:0] branch_addr_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_rdata_o;
  logic [31:0] instr_addr_o;
  logic        instr_err_o;

  int vectors = 0;
  int miscompares = 0;

  cv32e40x_instr_aligner #(.BOOT_ADDR(32'h0000_0080)) dut (
    .clk           (clk),
    .rst           (rst),
    .fetch_valid_i (fetch_valid_i),
    .fetch_rdata_i (fetch_rdata_i),
    .fetch_err_i   (fetch_err_i),
    .fetch_ready_o (fetch_ready_o),
    .branch_i      (branch_i),
    .branch_addr_i (branch_addr_i),
    .instr_valid_o (instr_valid_o),
    .instr_ready_i (instr_ready_i),
    .instr_rdata_o (instr_rdata_o),
    .instr_addr_o  (instr_addr_o),
    .instr_err_o   (instr_err_o)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply inputs, check at the falling edge, then advance past the rising edge.
  task automatic step(input string tag,
                      input logic fv, input logic [31:0] w, input logic ferr,
                      input logic rdy, input logic br, input logic [31:0] baddr,
                      input logic ev, input logic [31:0] erd, input logic [31:0] eaddr,
                      input logic eerr, input logic efr);
    fetch_valid_i = fv;
    fetch_rdata_i = w;
    fetch_err_i   = ferr;
    instr_ready_i = rdy;
    branch_i      = br;
    branch_addr_i = baddr;
    @(negedge clk);
    cmp({tag, ".valid"}, {31'h0, instr_valid_o}, {31'h0, ev});
    cmp({tag, ".fready"}, {31'h0, fetch_ready_o}, {31'h0, efr});
    if (ev) begin
      cmp({tag, ".rdata"}, instr_rdata_o, erd);
      cmp({tag, ".addr"}, instr_addr_o, eaddr);
      cmp({tag, ".err"}, {31'h0, instr_err_o}, {31'h0, eerr});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step("rst", 1'b1, 32'h00A0_0513, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    fetch_valid_i = 1'b0; fetch_rdata_i = 32'h0; fetch_err_i = 1'b0;
    instr_ready_i = 1'b1; branch_i = 1'b0; branch_addr_i = 32'h0;
    @(posedge clk); #1;

    // 1: aligned 32-bit instruction
    do_reset();
    step("t1.addi", 1, 32'h00A0_0513, 0, 1, 0, 0, 1, 32'h00A0_0513, 32'h80, 0, 1);
    step("t1.idle", 0, 32'h0, 0, 1, 0, 0, 0, 0, 0, 0, 0);

    // 2: two compressed in one word
    do_reset();
    step("t2.lo", 1, 32'h4501_4581, 0, 1, 0, 0, 1, 32'h0000_4581, 32'h80, 0, 1);
    step("t2.hi", 0, 32'h0, 0, 1, 0, 0, 1, 32'h0000_4501, 32'h82, 0, 0);
    step("t2.idle", 0, 32'h0, 0, 1, 0, 0, 0, 0, 0, 0, 0);

    // 3: straddling 32-bit instruction
    do_reset();
    step("t3.c0", 1, 32'h0513_4581, 0, 1, 0, 0, 1, 32'h0000_4581, 32'h80, 0, 1);
    step("t3.st", 1, 32'h4501_00A0, 0, 1, 0, 0, 1, 32'h00A0_0513, 32'h82, 0, 1);
    step("t3.c1", 0, 32'h0, 0, 1, 0, 0, 1, 32'h0000_4501, 32'h86, 0, 0);

    // 4: branch to halfword target, low half skipped
    step("t4.br", 1, 32'hDEAD_BEEF, 0, 1, 1, 32'h0000_0102, 0, 0, 0, 0, 0);
    step("t4.skip", 1, 32'h0001_1234, 0, 1, 0, 0, 0, 0, 0, 0, 1);
    step("t4.hi", 0, 32'h0, 0, 1, 0, 0, 1, 32'h0000_0001, 32'h102, 0, 0);
    step("t4.idle", 0, 32'h0, 0, 1, 0, 0, 0, 0, 0, 0, 0);

    // 5: straddle with error on second word
    do_reset();
    step("t5.c0", 1, 32'h0513_4581, 0, 1, 0, 0, 1, 32'h0000_4581, 32'h80, 0, 1);
    step("t5.st", 1, 32'h4501_00A0, 1, 1, 0, 0, 1, 32'h00A0_0513, 32'h82, 1, 1);
    step("t5.c1", 0, 32'h0, 0, 1, 0, 0, 1, 32'h0000_4501, 32'h86, 1, 0);

    // reset mid-straddle drops the residual
    do_reset();
    step("rs.c0", 1, 32'h0513_4581, 0, 1, 0, 0, 1, 32'h0000_4581, 32'h80, 0, 1);
    do_reset();
    step("rs.w", 1, 32'h00A0_0513, 0, 1, 0, 0, 1, 32'h00A0_0513, 32'h80, 0, 1);

    // 6: stall, then branch during stall
    do_reset();
    step("t6.s1", 1, 32'h00A0_0513, 0, 0, 0, 0, 1, 32'h00A0_0513, 32'h80, 0, 0);
    step("t6.s2", 1, 32'h00A0_0513, 0, 0, 0, 0, 1, 32'h00A0_0513, 32'h80, 0, 0);
    step("t6.s3", 1, 32'h00A0_0513, 0, 0, 0, 0, 1, 32'h00A0_0513, 32'h80, 0, 0);
    step("t6.s4", 1, 32'h00A0_0513, 0, 0, 0, 0, 1, 32'h00A0_0513, 32'h80, 0, 0);
    step("t6.br", 1, 32'h00A0_0513, 0, 0, 1, 32'h0000_0201, 0, 0, 0, 0, 0);
    step("t6.tgt", 1, 32'h00A0_0513, 0, 1, 0, 0, 1, 32'h00A0_0513, 32'h200, 0, 1);

    // PC wrap at top of address space
    step("wr.br", 0, 32'h0, 0, 1, 1, 32'hFFFF_FFFE, 0, 0, 0, 0, 0);
    step("wr.skip", 1, 32'h4501_0001, 0, 1, 0, 0, 0, 0, 0, 0, 1);
    step("wr.hi", 0, 32'h0, 0, 1, 0, 0, 1, 32'h0000_4501, 32'hFFFF_FFFE, 0, 0);
    step("wr.zero", 1, 32'h00A0_0513, 0, 1, 0, 0, 1, 32'h00A0_0513, 32'h0, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
